bram_loader: RTL and testbench

BRAM_LOADER -- requirements
Module: bram_loader

---
 rtl/bram_loader.sv | 236 +++++++++++++++++++++++
 tb/tb_bram_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_loader.sv
// -----------------------------------------------------------------------------
// bram_loader
//
// Purpose: receives a byte-serial boot image and writes it, one 32-bit word at
// a time, into an instruction BRAM. The CPU program counter is held via
// pc_stall until the whole image has been written.
//
// Stream format: 4-byte little-endian word count N, then 4*N payload bytes;
// each 4-byte group forms one little-endian word (first byte = bits 7:0).
// With LOADER_CHECKSUM_EN defined, one trailing byte follows the payload.
// It must equal the XOR of all payload bytes, otherwise the load ends in ERR.
//
// Optional feature macro: LOADER_CHECKSUM_EN (undefined by default).
//
// Ports:
//   clk       single clock, rising edge
//   rst       synchronous, active-low reset
//   s_valid   loader-stream byte valid
//   s_data    loader-stream byte
//   s_ready   loader accepts a byte this cycle
//   load_req  one-cycle re-arm request (honoured in DONE/ERR only)
//   w_addr    BRAM write word index
//   w_dat     BRAM write data
//   w_enb     BRAM write strobe
//   byte_enb  BRAM byte lanes
//   pc_stall  holds the CPU PC while no image is loaded
//   done      image loaded successfully
//   err       load aborted
// -----------------------------------------------------------------------------
`ifndef RAM_ADDR_WIDTH
`define RAM_ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module bram_loader #(
  parameter int ADDR_W = `RAM_ADDR_WIDTH,
  parameter int DATA_W = `DATA_WIDTH   // only 32 is supported
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              load_req,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_dat,
  output logic              w_enb,
  output logic [3:0]        byte_enb,
  output logic              pc_stall,
  output logic              done,
  output logic              err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    HDR   = 3'd0,
    DATA  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4,
    CSUM  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    HDR   = 3'd0,
    DATA  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;
`endif

  // Largest legal word count: the image may fill the memory exactly.
  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

  state_t              state_q;
  logic [1:0]          byte_cnt_q;
  logic [23:0]         byte_sr_q;    // first three bytes of the word in flight
  logic [ADDR_W:0]     word_idx_q;   // one extra bit so N = 2^ADDR_W cannot wrap
  logic [ADDR_W:0]     word_cnt_q;
  logic [ADDR_W-1:0]   w_addr_q;
  logic [DATA_W-1:0]   w_dat_q;
  logic                w_enb_q;
  logic [3:0]          byte_enb_q;
  logic                pc_stall_q;
  logic                done_q;
  logic                err_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum_q;
`endif

  logic                accept;
  logic                last_byte;
  logic [31:0]         word_full;
  logic                hdr_too_big;

  // Gated by rst so nothing is accepted while reset is being applied.
`ifdef LOADER_CHECKSUM_EN
  assign s_ready = rst && (state_q == HDR || state_q == DATA || state_q == CSUM);
`else
  assign s_ready = rst && (state_q == HDR || state_q == DATA);
`endif

  assign accept      = s_valid && s_ready;
  assign last_byte   = (byte_cnt_q == 2'd3);
  assign word_full   = {s_data, byte_sr_q};
  assign hdr_too_big = {1'b0, word_full} > MAX_WORDS;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= HDR;
      byte_cnt_q <= '0;
      byte_sr_q  <= '0;
      word_idx_q <= '0;
      word_cnt_q <= '0;
      w_addr_q   <= '0;
      w_dat_q    <= '0;
      w_enb_q    <= 1'b0;
      byte_enb_q <= 4'h0;
      pc_stall_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      case (state_q)
        HDR: begin
          if (accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            byte_sr_q  <= {s_data, byte_sr_q[23:8]};
            if (last_byte) begin
              word_cnt_q <= word_full[ADDR_W:0];
              if (hdr_too_big) begin
                state_q <= ERR;
                err_q   <= 1'b1;
              end else if (word_full == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                state_q    <= CSUM;
`else
                state_q    <= DONE;
                done_q     <= 1'b1;
                pc_stall_q <= 1'b0;
`endif
              end else begin
                state_q <= DATA;
              end
            end
          end
        end

        DATA: begin
          if (accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            byte_sr_q  <= {s_data, byte_sr_q[23:8]};
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ s_data;
`endif
            // Write strobe is registered here so it appears the cycle after
            // the 4th byte is accepted.
            if (last_byte) begin
              state_q    <= WRITE;
              w_addr_q   <= word_idx_q[ADDR_W-1:0];
              w_dat_q    <= word_full;
              w_enb_q    <= 1'b1;
              byte_enb_q <= 4'hF;
              word_idx_q <= word_idx_q + (ADDR_W+1)'(1);
            end
          end
        end

        WRITE: begin
          w_enb_q    <= 1'b0;
          byte_enb_q <= 4'h0;
          // word_idx_q already counts the word just written.
          if (word_idx_q != word_cnt_q) begin
            state_q <= DATA;
          end else begin
`ifdef LOADER_CHECKSUM_EN
            state_q    <= CSUM;
`else
            state_q    <= DONE;
            done_q     <= 1'b1;
            pc_stall_q <= 1'b0;
`endif
          end
        end

`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            if (s_data == csum_q) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              pc_stall_q <= 1'b0;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
        end
`endif

        DONE, ERR: begin
          if (load_req) begin
            state_q    <= HDR;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            word_cnt_q <= '0;
            pc_stall_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
          end
        end

        default: begin
          state_q <= HDR;
        end
      endcase
    end
  end

  assign w_addr   = w_addr_q;
  assign w_dat    = w_dat_q;
  assign w_enb    = w_enb_q;
  assign byte_enb = byte_enb_q;
  assign pc_stall = pc_stall_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_bram_loader.sv
// -----------------------------------------------------------------------------
// tb_bram_loader
//
// Directed bench for bram_loader (ADDR_W = 12, DATA_W = 32). Images are built
// as byte lists; the expected BRAM writes are derived from the stream format
// and queued, and a per-cycle compare process matches every w_enb pulse
// against that queue and checks the always-true output relations.
// Honours LOADER_CHECKSUM_EN by appending the XOR checksum byte.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_bram_loader;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'h00;
  logic              s_ready;
  logic              load_req = 1'b0;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_dat;
  logic              w_enb;
  logic [3:0]        byte_enb;
  logic              pc_stall;
  logic              done;
  logic              err;

  bram_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .load_req (load_req),
    .w_addr   (w_addr),
    .w_dat    (w_dat),
    .w_enb    (w_enb),
    .byte_enb (byte_enb),
    .pc_stall (pc_stall),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Model state
  logic [7:0]        pl[$];          // payload bytes of the current image
  logic [ADDR_W-1:0] exp_addr[$];
  logic [31:0]       exp_data[$];
  int                last_acc_cyc = -100;
  int                last_write_cyc = -100;
  int                done_cyc = -100;
  logic              prev_done = 1'b0;
  logic              check_en = 1'b0;
  int                gaps[8] = '{0, 2, 1, 3, 0, 0, 4, 1};
  int                gap_idx = 0;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_flip = 8'h00;
`endif

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Word w of the image: bytes 4w..4w+3, first byte in bits 7:0.
  function automatic logic [31:0] model_word(input int w);
    return {pl[4*w+3], pl[4*w+2], pl[4*w+1], pl[4*w]};
  endfunction

  // Per-cycle compare against the expected write queue and output relations.
  always @(negedge clk) begin
    if (check_en) begin
      if (w_enb === 1'b1) begin
        if (exp_addr.size() == 0) begin
          check("unexpected_write", 64'(w_enb), 64'd0);
        end else begin
          check("w_addr", 64'(w_addr), 64'(exp_addr[0]));
          check("w_dat", 64'(w_dat), 64'(exp_data[0]));
          void'(exp_addr.pop_front());
          void'(exp_data.pop_front());
        end
        check("byte_enb_write", 64'(byte_enb), 64'hF);
        check("s_ready_in_write", 64'(s_ready), 64'd0);
        check("write_latency", 64'(cyc), 64'(last_acc_cyc));
        last_write_cyc = cyc;
      end else begin
        check("w_enb_idle", 64'(w_enb), 64'd0);
        check("byte_enb_idle", 64'(byte_enb), 64'd0);
      end
      check("pc_stall_vs_done", 64'(pc_stall), 64'(!done));
      check("done_err_excl", 64'(done & err), 64'd0);
      if (done && !prev_done) done_cyc = cyc;
      prev_done = done;
    end
  end

  // Entered and left at a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    for (int i = 0; i < gap; i++) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = b;
    waited  = 0;
    while (!s_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) begin
      check("ready_timeout", 64'(s_ready), 64'd1);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 last_acc_cyc = cyc;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  function automatic int next_gap(input bit use_gaps);
    int g;
    g = use_gaps ? gaps[gap_idx % 8] : 0;
    gap_idx++;
    return g;
  endfunction

  // Sends header n and the payload in pl, then checks the final outcome.
  // poke pulses load_req mid-payload, which must be ignored.
  task automatic load_image(input logic [31:0] n, input bit use_gaps, input bit poke);
    logic exp_err;
    logic [7:0] x;
    exp_err = (n > 32'd4096);
    x = 8'h00;
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], next_gap(use_gaps));
    if (!exp_err) begin
      for (int w = 0; w < int'(n); w++) begin
        exp_addr.push_back(ADDR_W'(w));
        exp_data.push_back(model_word(w));
        for (int b = 0; b < 4; b++) begin
          send_byte(pl[4*w+b], next_gap(use_gaps));
          x = x ^ pl[4*w+b];
          if (poke && w == 0 && b == 1) begin
            load_req = 1'b1;
            @(negedge clk);
            load_req = 1'b0;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(x ^ csum_flip, next_gap(use_gaps));
      if (csum_flip != 8'h00) exp_err = 1'b1;
`endif
    end
    repeat (3) @(negedge clk);
    check("writes_outstanding", 64'(exp_addr.size()), 64'd0);
    check("done", 64'(done), 64'(!exp_err));
    check("err", 64'(err), 64'(exp_err));
    check("pc_stall_end", 64'(pc_stall), 64'(exp_err));
    check("s_ready_end", 64'(s_ready), 64'd0);
    if (!exp_err && n != 0) begin
      check("w_addr_hold", 64'(w_addr), 64'(n - 1));
      check("w_dat_hold", 64'(w_dat), 64'(model_word(int'(n) - 1)));
`ifndef LOADER_CHECKSUM_EN
      check("done_after_last_write", 64'(done_cyc - last_write_cyc), 64'd1);
`endif
    end
  endtask

  task automatic rearm();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check("rearm_pc_stall", 64'(pc_stall), 64'd1);
    check("rearm_done", 64'(done), 64'd0);
    check("rearm_err", 64'(err), 64'd0);
    check("rearm_s_ready", 64'(s_ready), 64'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_w_enb", 64'(w_enb), 64'd0);
    check("rst_byte_enb", 64'(byte_enb), 64'd0);
    check("rst_w_addr", 64'(w_addr), 64'd0);
    check("rst_w_dat", 64'(w_dat), 64'd0);
    check("rst_pc_stall", 64'(pc_stall), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    check_en = 1'b1;
    rst = 1'b1;
    #1 check("s_ready_after_rst", 64'(s_ready), 64'd1);
    @(negedge clk);

    // Two-word image, pinned by hand-computed words
    pl = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
    check("model_w0", 64'(model_word(0)), 64'h0050_0513);
    check("model_w1", 64'(model_word(1)), 64'h00A0_0593);
    load_image(32'd2, 1'b0, 1'b0);

    // Re-arm from DONE, same image with s_valid gaps, overwrites from addr 0
    rearm();
    load_image(32'd2, 1'b1, 1'b0);

    // One-word image with load_req pulsed mid-payload (ignored)
    rearm();
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    check("model_w_deadbeef", 64'(model_word(0)), 64'hEFBE_ADDE);
    load_image(32'd1, 1'b0, 1'b1);

    // Oversized header -> ERR without writes
    rearm();
    load_image(32'h0000_1001, 1'b0, 1'b0);
    rearm();

    // Empty image
    pl = {};
    load_image(32'd0, 1'b0, 1'b0);

    // Full-memory count is legal: header accepted, block waits for payload
    rearm();
    for (int i = 0; i < 4; i++) send_byte((i == 1) ? 8'h10 : 8'h00, 0);
    repeat (2) @(negedge clk);
    check("n_max_err", 64'(err), 64'd0);
    check("n_max_s_ready", 64'(s_ready), 64'd1);
    rst = 1'b0;
    #1 check("s_ready_in_rst", 64'(s_ready), 64'd0);
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;
    @(negedge clk);

    // Reset after 6 payload bytes abandons the image
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h02 : 8'h00, 0);
    exp_addr.push_back('0);
    exp_data.push_back(model_word(0));
    for (int i = 0; i < 6; i++) send_byte(pl[i], 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abandon_outstanding", 64'(exp_addr.size()), 64'd0);
    check_reset_outputs();
    rst = 1'b1;
    @(negedge clk);
    pl = '{8'h78, 8'h56, 8'h34, 8'h12};
    check("model_w_12345678", 64'(model_word(0)), 64'h1234_5678);
    load_image(32'd1, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    rearm();
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    check("model_w_44332211", 64'(model_word(0)), 64'h4433_2211);
    csum_flip = 8'h00;
    load_image(32'd1, 1'b0, 1'b0);
    rearm();
    csum_flip = 8'h01;   // sends 0x45 instead of 0x44
    load_image(32'd1, 1'b0, 1'b0);
    csum_flip = 8'h00;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
